data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have no parameters; geometry fixed: 8 sets x 4-byte blocks, direct-mapped, 3-bit tag, 3-bit index, 2-bit offset.
REQ-002 clock  input  1  rising-edge clock.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 read  input  1  CPU byte read request; held until busywait low.
REQ-005 write  input  1  CPU byte write request; held until busywait low.
REQ-006 address  input  8  CPU byte address: [7:5] tag, [4:2] index, [1:0] offset.
REQ-007 writedata  input  8  CPU store byte.
REQ-008 readdata  output  8  CPU load byte.
REQ-009 busywait  output  1  stall to CPU.
REQ-010 mem_read  output  1  block read request to data memory.
REQ-011 mem_write  output  1  block write request to data memory.
REQ-012 mem_address  output  6  block address {tag,index}.
REQ-013 mem_writedata  output  32  block to memory; byte n at bits [8n+7:8n].
REQ-014 mem_readdata  input  32  block from memory, same byte order.
REQ-015 mem_busywait  input  1  memory stall; low = transfer complete.

Function
REQ-016 Per set: valid bit, dirty bit, 3-bit tag, 32-bit block.
REQ-017 hit = valid[index] and tag[index]==address[7:5], combinational.
REQ-018 busywait = (read or write) and not (state==IDLE and hit), combinational.
REQ-019 Read hit: readdata = block[index] byte address[1:0], combinational, zero stall.
REQ-020 Write hit: at posedge in IDLE, selected byte <= writedata, dirty[index] <= 1; zero stall.
REQ-021 read and write both high: treated as write.
REQ-022 FSM states IDLE, WRITE_BACK, MEM_READ, UPDATE.
REQ-023 IDLE, request and miss: -> WRITE_BACK if valid and dirty, else -> MEM_READ.
REQ-024 WRITE_BACK: mem_write=1, mem_address={stored tag,index}, mem_writedata=block; -> MEM_READ at first posedge where mem_busywait==0 after it was seen high.
REQ-025 MEM_READ: mem_read=1, mem_address={address[7:5],index}; -> UPDATE at first posedge where mem_busywait==0 after it was seen high.
REQ-026 UPDATE: block <= mem_readdata, tag <= address[7:5], valid <= 1, dirty <= 0; -> IDLE next posedge; access then completes as hit.
REQ-027 mem_read and mem_write never high together; both low in IDLE and UPDATE.
REQ-028 Requests dropping mid-miss: current FSM sequence still runs to IDLE.

Reset
REQ-029 Reset asserted: state=IDLE, all valid=0, all dirty=0, mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, readdata=0 unless a hit is presented.
REQ-030 Reset mid-miss: transfer abandoned immediately; memory request lines drop same instant; tags and data need no clearing.

Configuration
REQ-031 Macro DATA_CACHE_STATS_EN defined: adds outputs hit_count[15:0], miss_count[15:0], reset to 0, saturating at 16'hFFFF.
REQ-032 miss_count increments on each IDLE->WRITE_BACK/MEM_READ transition; hit_count increments on each access completing in IDLE whose previous state was not UPDATE.
REQ-033 Macro undefined: counter ports and logic absent; all other behaviour identical.

Verification
REQ-034 Reset, read addr 0x25 with memory block 6'h09=0xDDCCBBAA -> mem_read, mem_address=6'h09, then readdata=0xBB, busywait low; no write-back.
REQ-035 Write 0x5A to 0x25 after REQ-034 -> zero stall, dirty[1]=1; read 0x25 -> 0x5A.
REQ-036 Then read 0x45 (same index, tag 2) -> WRITE_BACK mem_address=6'h09, mem_writedata=0xDDCC5AAA, then MEM_READ mem_address=6'h11.
REQ-037 Assert reset during MEM_READ -> mem_read low immediately, state IDLE, prior hit on 0x25 now misses.
REQ-038 With DATA_CACHE_STATS_EN: sequence REQ-034..REQ-036 -> miss_count=2, hit_count=2.

Source files
------------

// File: rtl/data_cache.sv
// data_cache -- direct-mapped, write-back byte cache for an 8-bit CPU.
//   Geometry: 8 sets x 4-byte blocks.
//   Address map: [7:5] tag, [4:2] index, [1:0] byte offset.
//   Hits complete with zero stall. Read and write hits are combinational
//   and write hits commit at the clock edge. A miss runs
//   IDLE -> (WRITE_BACK) -> MEM_READ -> UPDATE -> IDLE.
//   The WRITE_BACK state is entered only when the victim block is dirty.
//
// Ports
//   clock, reset           rising-edge clock; asynchronous active-high reset
//   read, write            CPU byte request, held until busywait drops
//   address, writedata     CPU byte address / store byte
//   readdata, busywait     CPU load byte / stall
//   mem_read, mem_write    block request to data memory (mutually exclusive)
//   mem_address            block address {tag,index}
//   mem_writedata          victim block; byte n at [8n+7:8n]
//   mem_readdata           fill block, same byte order
//   mem_busywait           memory stall; a transfer completes when it falls
//                          after having been seen high
//
// Optional feature (macro DATA_CACHE_STATS_EN)
//   hit_count, miss_count  16-bit saturating access counters
module data_cache (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic        busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
`ifdef DATA_CACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    MEM_READ   = 2'd2,
    UPDATE     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        seen_q, seen_d;   // mem_busywait observed high in this transfer
  logic [7:0]  valid_q;
  logic [7:0]  dirty_q;
  logic [2:0]  tag_q   [8];
  logic [31:0] block_q [8];

  logic [2:0]  tag_in;
  logic [2:0]  index;
  logic [4:0]  bit_off;
  logic        req;
  logic        hit;
  logic        write_hit;

  assign tag_in  = address[7:5];
  assign index   = address[4:2];
  assign bit_off = {address[1:0], 3'b000};
  assign req     = read | write;
  assign hit     = valid_q[index] && (tag_q[index] == tag_in);
  // A simultaneous read and write is served as a write.
  assign write_hit = (state_q == IDLE) && write && hit;

  assign busywait = req && !((state_q == IDLE) && hit);
  assign readdata = hit ? block_q[index][bit_off +: 8] : 8'h00;

  always_comb begin
    state_d       = state_q;
    seen_d        = seen_q;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = 6'h00;
    mem_writedata = 32'h0;
    case (state_q)
      IDLE: begin
        seen_d = 1'b0;
        if (req && !hit)
          state_d = (valid_q[index] && dirty_q[index]) ? WRITE_BACK : MEM_READ;
      end
      WRITE_BACK: begin
        mem_write     = 1'b1;
        mem_address   = {tag_q[index], index};
        mem_writedata = block_q[index];
        if (mem_busywait) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          seen_d  = 1'b0;
          state_d = MEM_READ;
        end
      end
      MEM_READ: begin
        mem_read    = 1'b1;
        mem_address = {tag_in, index};
        if (mem_busywait) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          seen_d  = 1'b0;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        seen_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: reset abandons any transfer in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      seen_q  <= 1'b0;
      valid_q <= 8'h00;
      dirty_q <= 8'h00;
    end else begin
      state_q <= state_d;
      seen_q  <= seen_d;
      if (state_q == UPDATE) begin
        valid_q[index] <= 1'b1;
        dirty_q[index] <= 1'b0;
      end else if (write_hit) begin
        dirty_q[index] <= 1'b1;
      end
    end
  end

  // Tag and data storage are qualified by valid, so they carry no reset.
  always_ff @(posedge clock) begin
    if (state_q == UPDATE) begin
      block_q[index] <= mem_readdata;
      tag_q[index]   <= tag_in;
    end else if (write_hit) begin
      block_q[index][bit_off +: 8] <= writedata;
    end
  end

`ifdef DATA_CACHE_STATS_EN
  state_t      prev_q;
  logic [15:0] hit_q;
  logic [15:0] miss_q;
  logic        hit_evt;
  logic        miss_evt;

  // A hit straight after a fill is the tail of a miss, not a new hit.
  assign hit_evt  = (state_q == IDLE) && req && hit && (prev_q != UPDATE);
  assign miss_evt = (state_q == IDLE) && (state_d != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q <= IDLE;
      hit_q  <= 16'h0000;
      miss_q <= 16'h0000;
    end else begin
      prev_q <= state_q;
      if (hit_evt && (hit_q != 16'hFFFF))
        hit_q <= hit_q + 16'h0001;
      if (miss_evt && (miss_q != 16'hFFFF))
        miss_q <= miss_q + 16'h0001;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

  logic        clock;
  logic        reset;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;
`ifdef DATA_CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  int checks = 0;
  int errors = 0;

  data_cache dut (
    .clock         (clock),
    .reset         (reset),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
`ifdef DATA_CACHE_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One full cycle; returns on the falling edge where inputs are driven.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; read = 1'b0; write = 1'b0; address = 8'h00;
    writedata = 8'h00; mem_readdata = 32'h0; mem_busywait = 1'b0;
    tick();
    tick();
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_read: got %b expected 0", mem_read); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_mem_write: got %b expected 0", mem_write); end
    checks++; if (mem_address !== 6'h00) begin errors++; $display("FAIL rst_mem_address: got %h expected 00", mem_address); end
    checks++; if (mem_writedata !== 32'h0) begin errors++; $display("FAIL rst_mem_writedata: got %h expected 0", mem_writedata); end
    checks++; if (readdata !== 8'h00) begin errors++; $display("FAIL rst_readdata: got %h expected 00", readdata); end
    checks++; if (busywait !== 1'b0) begin errors++; $display("FAIL rst_busywait_idle: got %b expected 0", busywait); end
    read = 1'b1; address = 8'h25;
    #1;
    checks++; if (busywait !== 1'b1) begin errors++; $display("FAIL rst_all_invalid: busywait got %b expected 1", busywait); end
`ifdef DATA_CACHE_STATS_EN
    checks++; if (hit_count !== 16'h0) begin errors++; $display("FAIL rst_hit_count: got %h expected 0", hit_count); end
    checks++; if (miss_count !== 16'h0) begin errors++; $display("FAIL rst_miss_count: got %h expected 0", miss_count); end
`endif
    read = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read_miss();
    read = 1'b1; address = 8'h25;
    #1;
    checks++; if (busywait !== 1'b1) begin errors++; $display("FAIL rm_busy_req: got %b expected 1", busywait); end
    tick();
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rm_mem_read: got %b expected 1", mem_read); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rm_no_writeback: mem_write got %b expected 0", mem_write); end
    checks++; if (mem_address !== 6'h09) begin errors++; $display("FAIL rm_mem_address: got %h expected 09", mem_address); end
    // Memory has not yet raised busywait: the fill must not complete.
    tick();
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rm_wait_handshake: mem_read got %b expected 1", mem_read); end
    mem_busywait = 1'b1;
    tick();
    mem_busywait = 1'b0; mem_readdata = 32'hDDCCBBAA;
    tick();
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rm_update_mem_read: got %b expected 0", mem_read); end
    checks++; if (busywait !== 1'b1) begin errors++; $display("FAIL rm_update_busy: got %b expected 1", busywait); end
    tick();
    checks++; if (busywait !== 1'b0) begin errors++; $display("FAIL rm_done_busy: got %b expected 0", busywait); end
    checks++; if (readdata !== 8'hBB) begin errors++; $display("FAIL rm_readdata: got %h expected BB", readdata); end
    tick();
    read = 1'b0;
  endtask

  task automatic test_write_hit();
    write = 1'b1; address = 8'h25; writedata = 8'h5A;
    #1;
    checks++; if (busywait !== 1'b0) begin errors++; $display("FAIL wh_zero_stall: busywait got %b expected 0", busywait); end
    tick();
    write = 1'b0; read = 1'b1; address = 8'h24;
    #1;
    checks++; if (readdata !== 8'hAA) begin errors++; $display("FAIL wh_byte0: got %h expected AA", readdata); end
    address = 8'h27;
    #1;
    checks++; if (readdata !== 8'hDD) begin errors++; $display("FAIL wh_byte3: got %h expected DD", readdata); end
    address = 8'h25;
    #1;
    checks++; if (readdata !== 8'h5A) begin errors++; $display("FAIL wh_readback: got %h expected 5A", readdata); end
    checks++; if (busywait !== 1'b0) begin errors++; $display("FAIL wh_read_stall: busywait got %b expected 0", busywait); end
    tick();
    read = 1'b0;
  endtask

  task automatic test_write_back();
    read = 1'b1; address = 8'h45;
    #1;
    checks++; if (busywait !== 1'b1) begin errors++; $display("FAIL wb_busy: got %b expected 1", busywait); end
    tick();
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL wb_mem_write: got %b expected 1", mem_write); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL wb_mem_read_excl: got %b expected 0", mem_read); end
    checks++; if (mem_address !== 6'h09) begin errors++; $display("FAIL wb_mem_address: got %h expected 09", mem_address); end
    checks++; if (mem_writedata !== 32'hDDCC5AAA) begin errors++; $display("FAIL wb_mem_writedata: got %h expected DDCC5AAA", mem_writedata); end
    mem_busywait = 1'b1;
    tick();
    mem_busywait = 1'b0;
    tick();
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL wb_then_mem_read: got %b expected 1", mem_read); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL wb_then_mem_write: got %b expected 0", mem_write); end
    checks++; if (mem_address !== 6'h11) begin errors++; $display("FAIL wb_fill_address: got %h expected 11", mem_address); end
`ifdef DATA_CACHE_STATS_EN
    checks++; if (miss_count !== 16'd2) begin errors++; $display("FAIL stats_miss: got %0d expected 2", miss_count); end
    checks++; if (hit_count !== 16'd2) begin errors++; $display("FAIL stats_hit: got %0d expected 2", hit_count); end
`endif
  endtask

  task automatic test_reset_mid_miss();
    mem_busywait = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rmm_mem_read_drop: got %b expected 0", mem_read); end
    checks++; if (mem_address !== 6'h00) begin errors++; $display("FAIL rmm_mem_address: got %h expected 00", mem_address); end
`ifdef DATA_CACHE_STATS_EN
    checks++; if (miss_count !== 16'd0) begin errors++; $display("FAIL rmm_stats_clear: got %0d expected 0", miss_count); end
`endif
    tick();
    reset = 1'b0; mem_busywait = 1'b0; read = 1'b0;
    tick();
    read = 1'b1; address = 8'h25;
    #1;
    checks++; if (busywait !== 1'b1) begin errors++; $display("FAIL rmm_old_hit_misses: busywait got %b expected 1", busywait); end
    checks++; if (readdata !== 8'h00) begin errors++; $display("FAIL rmm_readdata: got %h expected 00", readdata); end
    tick();
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rmm_refill_read: got %b expected 1", mem_read); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rmm_dirty_cleared: mem_write got %b expected 0", mem_write); end
    mem_busywait = 1'b1;
    tick();
    mem_busywait = 1'b0; mem_readdata = 32'hDDCC5AAA;
    tick();
    tick();
    checks++; if (readdata !== 8'h5A) begin errors++; $display("FAIL rmm_refill_data: got %h expected 5A", readdata); end
    tick();
    read = 1'b0;
  endtask

  task automatic test_read_write_both();
    read = 1'b1; write = 1'b1; address = 8'h26; writedata = 8'h77;
    #1;
    checks++; if (busywait !== 1'b0) begin errors++; $display("FAIL rw_zero_stall: got %b expected 0", busywait); end
    tick();
    write = 1'b0;
    #1;
    checks++; if (readdata !== 8'h77) begin errors++; $display("FAIL rw_as_write: got %h expected 77", readdata); end
    tick();
    read = 1'b0;
  endtask

  task automatic test_write_miss();
    write = 1'b1; address = 8'hE5; writedata = 8'h99;
    #1;
    checks++; if (busywait !== 1'b1) begin errors++; $display("FAIL wm_busy: got %b expected 1", busywait); end
    tick();
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL wm_writeback: got %b expected 1", mem_write); end
    checks++; if (mem_address !== 6'h09) begin errors++; $display("FAIL wm_victim_addr: got %h expected 09", mem_address); end
    checks++; if (mem_writedata !== 32'hDD775AAA) begin errors++; $display("FAIL wm_victim_data: got %h expected DD775AAA", mem_writedata); end
    mem_busywait = 1'b1;
    tick();
    mem_busywait = 1'b0;
    tick();
    checks++; if (mem_address !== 6'h39) begin errors++; $display("FAIL wm_fill_addr: got %h expected 39", mem_address); end
    mem_busywait = 1'b1;
    tick();
    mem_busywait = 1'b0; mem_readdata = 32'h44332211;
    tick();
    tick();
    checks++; if (busywait !== 1'b0) begin errors++; $display("FAIL wm_done_busy: got %b expected 0", busywait); end
    tick();
    write = 1'b0; read = 1'b1;
    #1;
    checks++; if (readdata !== 8'h99) begin errors++; $display("FAIL wm_stored: got %h expected 99", readdata); end
    address = 8'hE4;
    #1;
    checks++; if (readdata !== 8'h11) begin errors++; $display("FAIL wm_fill_byte0: got %h expected 11", readdata); end
    tick();
    read = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_write_hit();
    test_write_back();
    test_reset_mid_miss();
    test_read_write_both();
    test_write_miss();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
